// File: rtl/if_stage.sv
// Instruction fetch stage: a PC sequencer issues one-cycle-latency memory reads
// under a credit rule, and the responses land in a small in-order instruction
// buffer that feeds the decoder through a valid/ready handshake.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           fifo_q [DEPTH];

    logic   pop;
    logic   wr_en;
    logic   credit_ok;
    entry_t head;

    // Low address bits are forced to zero on redirect, so they are never read.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[1:0];

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o & instr_ready_i;
    // A response is only written when it was not killed by a redirect this cycle.
    assign wr_en         = inflight_q & ~redirect_i;
    // count + inflight - pop < DEPTH, rearranged to avoid a subtraction.
    assign credit_ok     = ({1'b0, count_q} + (CNT_W + 1)'(inflight_q))
                           < (DEPTH_W + (CNT_W + 1)'(pop));
    assign imem_req_o    = (state_q == RUN) & ~redirect_i & credit_ok;
    assign imem_addr_o   = pc_q;

    // Storage is masked while empty so outputs read zero out of reset.
    assign head    = fifo_q[rd_ptr_q];
    assign instr_o = instr_valid_o ? head.instr : '0;
    assign pc_o    = instr_valid_o ? head.pc    : '0;

    // Next-state logic for the fetch FSM, PC, in-flight tracker and FIFO control.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = start_i ? RUN : IDLE;
        pc_d       = pc_q;
        inflight_d = imem_req_o;
        req_pc_d   = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req_o) begin
                pc_d = pc_q + 32'd4;
            end
            if (wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers, cleared asynchronously so outputs reset without a clock.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Instruction buffer storage: captures the returning response at the tail.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; count_q alone decides which entries are valid.
        if (wr_en) begin
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_data_i};
        end
    end

    // The credit rule must make a write into a full buffer impossible.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
        !(wr_en && (count_q == DEPTH_C)));

endmodule
